// File: rtl/dct_pkg.sv
// Shared constants, FSM state type and block-count helper for the DCT line-buffer controller.
// Optional block-position tracking is enabled with the DCT_LB_POS_EN macro.
package dct_pkg;

    localparam int BLK_N     = 8;
    localparam int DEF_IMG_W = 1920;
    localparam int DEF_IMG_H = 1080;
    localparam int CNT_W     = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_N - 1);

    typedef enum logic [1:0] {
        ST_CLR,
        ST_FILL,
        ST_DRAIN
    } state_t;

    // Partial blocks at the bottom edge still count as a whole block row.
    function automatic int blk_count(input int pixels);
        return (pixels + BLK_N - 1) / BLK_N;
    endfunction

endpackage

// File: rtl/dct_lb_ctrl_if.sv
// Row-in / column-out handshake bundle between the DCT pipeline and the line-buffer controller.
interface dct_lb_ctrl_if;

    logic i_in_valid;
    logic o_in_ready;
    logic o_out_valid;
    logic i_out_ready;

    modport master (
        output i_in_valid,
        output i_out_ready,
        input  o_in_ready,
        input  o_out_valid
    );

    modport slave (
        input  i_in_valid,
        input  i_out_ready,
        output o_in_ready,
        output o_out_valid
    );

endinterface

// File: rtl/dct_blk_pos_cnt.sv
// Tracks the (x, y) position of the 8x8 block being drained, raster order, with frame markers.
// Only instantiated when DCT_LB_POS_EN is defined.
module dct_blk_pos_cnt
    import dct_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       draining,
    output logic [7:0] blk_x,
    output logic [7:0] blk_y,
    output logic       sof,
    output logic       eof
);

    localparam logic [7:0] X_LAST = 8'(IMG_W / BLK_N - 1);
    localparam logic [7:0] Y_LAST = 8'(blk_count(IMG_H) - 1);

    logic x_wrap;
    logic y_wrap;

    assign x_wrap = (blk_x == X_LAST);
    assign y_wrap = (blk_y == Y_LAST);

    // Flush never reaches here: position only moves on a completed block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_x <= '0;
            blk_y <= '0;
        end else if (advance) begin
            if (x_wrap) begin
                blk_x <= '0;
                blk_y <= y_wrap ? 8'd0 : blk_y + 8'd1;
            end else begin
                blk_x <= blk_x + 8'd1;
            end
        end
    end

    assign sof = draining && (blk_x == 8'd0) && (blk_y == 8'd0);
    assign eof = advance && x_wrap && y_wrap;

endmodule

// File: rtl/dct_lb_ctrl.sv
// Transpose line-buffer controller: clears the buffer, writes 8 rows, then reads 8 columns per block.
// Defining DCT_LB_POS_EN adds block position outputs (o_blk_x, o_blk_y, o_sof, o_eof).
module dct_lb_ctrl
    import dct_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    dct_lb_ctrl_if.slave bus,
    output logic         o_lb_write,
    output logic         o_lb_read,
    output logic         o_lb_clr,
    output logic         o_blk_done,
    output logic         o_busy
`ifdef DCT_LB_POS_EN
    ,
    output logic [7:0]   o_blk_x,
    output logic [7:0]   o_blk_y,
    output logic         o_sof,
    output logic         o_eof
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic in_ready;
    logic out_valid;
    logic lb_write;
    logic lb_read;
    logic lb_clr;
    logic blk_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_CLR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Ready/valid are masked by flush so the strobes stay equal to the handshakes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        lb_write  = 1'b0;
        lb_read   = 1'b0;
        lb_clr    = 1'b0;
        blk_done  = 1'b0;

        case (state)
            ST_CLR: begin
                lb_clr    = 1'b1;
                state_nxt = ST_FILL;
                cnt_nxt   = '0;
            end
            ST_FILL: begin
                in_ready = !i_flush;
                lb_write = bus.i_in_valid & in_ready;
                if (lb_write) begin
                    cnt_nxt = cnt + 3'd1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                out_valid = !i_flush;
                lb_read   = out_valid & bus.i_out_ready;
                if (lb_read) begin
                    cnt_nxt = cnt + 3'd1;
                    if (cnt == CNT_LAST) begin
                        blk_done  = 1'b1;
                        state_nxt = ST_FILL;
                    end
                end
            end
            default: begin
                state_nxt = ST_CLR;
                cnt_nxt   = '0;
            end
        endcase

        if (i_flush) begin
            state_nxt = ST_CLR;
            cnt_nxt   = '0;
        end
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_out_valid = out_valid;
    assign o_lb_write      = lb_write;
    assign o_lb_read       = lb_read;
    assign o_lb_clr        = lb_clr;
    assign o_blk_done      = blk_done;
    assign o_busy          = (state == ST_DRAIN) || ((state == ST_FILL) && (cnt != '0));

`ifdef DCT_LB_POS_EN
    dct_blk_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .advance  (blk_done),
        .draining (state == ST_DRAIN),
        .blk_x    (o_blk_x),
        .blk_y    (o_blk_y),
        .sof      (o_sof),
        .eof      (o_eof)
    );
`endif

endmodule

// File: tb/tb_dct_lb_ctrl.sv
// Self-checking bench for dct_lb_ctrl: directed scenarios plus random traffic against a row/column model.
// Position outputs are checked as well when DCT_LB_POS_EN is defined.
module tb_dct_lb_ctrl;

    localparam int TB_W   = 1920;
    localparam int TB_H   = 24;
    localparam int W_BLKS = TB_W / 8;
    localparam int H_BLKS = (TB_H + 7) / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic lb_write, lb_read, lb_clr, blk_done, busy;
`ifdef DCT_LB_POS_EN
    logic [7:0] blk_x, blk_y;
    logic       sof, eof;
`endif

    dct_lb_ctrl_if bus ();

    dct_lb_ctrl #(
        .IMG_W (TB_W),
        .IMG_H (TB_H)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .bus        (bus),
        .o_lb_write (lb_write),
        .o_lb_read  (lb_read),
        .o_lb_clr   (lb_clr),
        .o_blk_done (blk_done),
        .o_busy     (busy)
`ifdef DCT_LB_POS_EN
        ,
        .o_blk_x    (blk_x),
        .o_blk_y    (blk_y),
        .o_sof      (sof),
        .o_eof      (eof)
`endif
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: clearing flag, rows stored so far (8 = full, draining), columns already sent.
    bit m_clr;
    int m_rows;
    int m_cols;
    int m_bx;
    int m_by;

    bit e_in_ready, e_out_valid, e_write, e_read, e_clr, e_done, e_busy, e_drain;
    int e_cnt;

    int wr_seen, rd_seen, done_seen, eof_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clr  = 1'b1;
        m_rows = 0;
        m_cols = 0;
        m_bx   = 0;
        m_by   = 0;
    endtask

    task automatic model_outputs(input bit v, input bit r, input bit f);
        e_in_ready  = 1'b0;
        e_out_valid = 1'b0;
        e_write     = 1'b0;
        e_read      = 1'b0;
        e_clr       = 1'b0;
        e_done      = 1'b0;
        e_busy      = 1'b0;
        e_drain     = 1'b0;
        e_cnt       = 0;
        if (m_clr) begin
            e_clr = 1'b1;
        end else if (m_rows < 8) begin
            e_in_ready = !f;
            e_write    = v && !f;
            e_cnt      = m_rows;
            e_busy     = (m_rows != 0);
        end else begin
            e_drain     = 1'b1;
            e_out_valid = !f;
            e_read      = r && !f;
            e_done      = e_read && (m_cols == 7);
            e_cnt       = m_cols;
            e_busy      = 1'b1;
        end
    endtask

    task automatic model_advance(input bit f);
        if (e_done) begin
            if (m_bx == W_BLKS - 1) begin
                m_bx = 0;
                m_by = (m_by == H_BLKS - 1) ? 0 : m_by + 1;
            end else begin
                m_bx++;
            end
        end
        if (f) begin
            m_clr = 1'b1;
        end else if (m_clr) begin
            m_clr  = 1'b0;
            m_rows = 0;
            m_cols = 0;
        end else if (m_rows < 8) begin
            if (e_write) m_rows++;
            m_cols = 0;
        end else if (e_read) begin
            m_cols++;
            if (m_cols == 8) begin
                m_rows = 0;
                m_cols = 0;
            end
        end
    endtask

    task automatic check_output(input bit v, input bit r, input bit f);
        model_outputs(v, r, f);
        check_val("in_ready",  bus.o_in_ready,  e_in_ready);
        check_val("out_valid", bus.o_out_valid, e_out_valid);
        check_val("lb_write",  lb_write,        e_write);
        check_val("lb_read",   lb_read,         e_read);
        check_val("lb_clr",    lb_clr,          e_clr);
        check_val("blk_done",  blk_done,        e_done);
        check_val("busy",      busy,            e_busy);
        check_val("cnt",       dut.cnt,         e_cnt);
`ifdef DCT_LB_POS_EN
        check_val("blk_x", blk_x, m_bx);
        check_val("blk_y", blk_y, m_by);
        check_val("sof",   sof,   e_drain && m_bx == 0 && m_by == 0);
        check_val("eof",   eof,   e_done && m_bx == W_BLKS - 1 && m_by == H_BLKS - 1);
        eof_seen += int'(eof);
`endif
        wr_seen   += int'(lb_write);
        rd_seen   += int'(lb_read);
        done_seen += int'(blk_done);
    endtask

    // Entered and left just after a rising edge; sampled on the falling edge.
    task automatic apply_stimulus(input bit v, input bit r, input bit f);
        bus.i_in_valid  = v;
        bus.i_out_ready = r;
        flush           = f;
        @(negedge clk);
        check_output(v, r, f);
        @(posedge clk);
        model_advance(f);
        #1;
    endtask

    task automatic clear_tallies();
        wr_seen   = 0;
        rd_seen   = 0;
        done_seen = 0;
    endtask

    task automatic run_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output(bus.i_in_valid, bus.i_out_ready, flush);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int k;

        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b0;
        flush           = 1'b0;
        rst_n           = 1'b0;
        eof_seen        = 0;
        model_reset();
        clear_tallies();

        // Reset state, then one clear cycle and a full block at full rate
        repeat (2) @(posedge clk);
        #1;
        run_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0);
        clear_tallies();
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
        check_val("basic_writes", wr_seen, 8);
        check_val("basic_reads", rd_seen, 8);
        check_val("basic_done", done_seen, 1);

        // Stalled drain with ready pattern 1,0,0,1...
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
        clear_tallies();
        k = 0;
        while (done_seen == 0 && k < 40) begin
            apply_stimulus(1'b1, rdy_pat[k % 4], 1'b0);
            k++;
        end
        check_val("stall_reads", rd_seen, 8);
        check_val("stall_writes", wr_seen, 0);
        check_val("stall_done", done_seen, 1);

        // Flush after 5 rows: clear cycle, then 8 fresh rows before draining
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        clear_tallies();
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
        check_val("flush_refill_writes", wr_seen, 8);
        apply_stimulus(1'b0, 1'b0, 1'b0);

        // Flush together with the last read suppresses completion
        clear_tallies();
        for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_val("flush_last_done", done_seen, 0);
        check_val("flush_last_reads", rd_seen, 7);
        apply_stimulus(1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
        bus.i_out_ready = 1'b1;
        #2;
        run_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 31) == 0));
        end

`ifdef DCT_LB_POS_EN
        // Full-rate blocks until the frame wraps
        eof_seen = 0;
        k = 0;
        while (eof_seen == 0 && k < (W_BLKS * H_BLKS + 4) * 16 + 32) begin
            apply_stimulus(1'b1, 1'b1, 1'b0);
            k++;
        end
        check_val("eof_count", eof_seen, 1);
        check_val("blk_y_after_eof", blk_y, 0);
        for (int i = 0; i < W_BLKS * 16; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
        check_val("eof_no_repeat", eof_seen, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
